// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer sequencer.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWrite = 3'd2,
    StDone  = 3'd3,
    StAbort = 3'd4
  } dma_state_e;

  localparam logic [1:0] MST_WE_READ = 2'b00;
  localparam logic [1:0] MST_WE_WORD = 2'b11;
  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/dma_timeout_cnt.sv
// Saturating bus-wait counter; hit_o flags that the next waiting cycle reaches the limit.
module dma_timeout_cnt
  import dma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TIMER_W-1:0] HitVal = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MaxVal = {TIMER_W{1'b1}};

  logic [TIMER_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Used only in a not-ready cycle, which would be waiting cycle number cnt_q + 1.
  assign hit_o = (cnt_q >= HitVal);

endmodule

// File: rtl/dma_engine.sv
// DMA transfer sequencer: moves words one at a time from source to destination
// over a single-master bus and reports busy/interrupt/error status.
module dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_STEP      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_trans_start,
  input  logic        direction_bit,
  input  logic        int_enabled,
  input  logic [15:0] dma_p1_start_addr,
  input  logic [15:0] dma_p2_start_addr,
  input  logic [15:0] dma_transfer_len,
  input  logic        clear_int,
  output logic        int_gen,
  output logic        dma_busy,
  output logic        dma_error,
  output logic        mst_en,
  output logic [1:0]  mst_we,
  output logic [15:0] mst_addr,
  output logic [15:0] mst_wdata,
  input  logic [15:0] mst_rdata,
  input  logic        mst_ready,
  input  logic        mst_resp
);

  localparam logic [15:0] Step = 16'(ADDR_STEP);

  dma_state_e  state_d, state_q;
  logic [15:0] src_d, src_q;
  logic [15:0] dst_d, dst_q;
  logic [15:0] cnt_d, cnt_q;
  logic [15:0] data_d, data_q;
  logic        int_en_d, int_en_q;
  logic        int_gen_d, int_gen_q;
  logic        err_d, err_q;
  logic        busy_d, busy_q;

  logic tmr_clr, tmr_en, tmr_hit;
  logic int_set, err_set;

  // Timer enable is derived from state, not mst_en, to keep hit out of the output path.
  assign tmr_en = ((state_q == StRead) || (state_q == StWrite)) && !mst_ready;

  dma_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i(clk),
    .rst_i(reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .hit_o(tmr_hit)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    int_en_d  = int_en_q;
    int_set   = 1'b0;
    err_set   = 1'b0;
    mst_en    = 1'b0;
    mst_we    = MST_WE_READ;
    mst_addr  = 16'h0000;
    mst_wdata = 16'h0000;

    case (state_q)
      StIdle: begin
        if (dma_trans_start) begin
          int_en_d = int_enabled;
          if (dma_transfer_len != 16'h0000) begin
            src_d   = direction_bit ? {dma_p2_start_addr[15:1], 1'b0}
                                    : {dma_p1_start_addr[15:1], 1'b0};
            dst_d   = direction_bit ? {dma_p1_start_addr[15:1], 1'b0}
                                    : {dma_p2_start_addr[15:1], 1'b0};
            cnt_d   = dma_transfer_len;
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: begin
        mst_en   = 1'b1;
        mst_we   = MST_WE_READ;
        mst_addr = src_q;
        if (mst_ready) begin
          if (mst_resp) begin
            state_d = StAbort;
          end else begin
            data_d  = mst_rdata;
            src_d   = src_q + Step;
            state_d = StWrite;
          end
        end else if (tmr_hit) begin
          state_d = StAbort;
        end
      end
      StWrite: begin
        mst_en    = 1'b1;
        mst_we    = MST_WE_WORD;
        mst_addr  = dst_q;
        mst_wdata = data_q;
        if (mst_ready) begin
          if (mst_resp) begin
            state_d = StAbort;
          end else begin
            dst_d   = dst_q + Step;
            cnt_d   = cnt_q - 16'h0001;
            state_d = (cnt_q == 16'h0001) ? StDone : StRead;
          end
        end else if (tmr_hit) begin
          state_d = StAbort;
        end
      end
      StDone: begin
        int_set = int_en_q;
        state_d = StIdle;
      end
      StAbort: begin
        err_set = 1'b1;
        int_set = int_en_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Every READ/WRITE entry is a state change (READ and WRITE always alternate).
    tmr_clr = (state_d != state_q);

    // Set beats a simultaneous clear.
    int_gen_d = clear_int ? 1'b0 : int_gen_q;
    if (int_set) int_gen_d = 1'b1;
    err_d = clear_int ? 1'b0 : err_q;
    if (err_set) err_d = 1'b1;

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= 16'h0000;
      dst_q     <= 16'h0000;
      cnt_q     <= 16'h0000;
      data_q    <= 16'h0000;
      int_en_q  <= 1'b0;
      int_gen_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      int_en_q  <= int_en_d;
      int_gen_q <= int_gen_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign int_gen   = int_gen_q;
  assign dma_error = err_q;
  assign dma_busy  = busy_q;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: table of transfers, a bus responder with a
// transaction scoreboard, and hand-written reset/clear corner sequences.
module tb_dma_engine;
  import dma_pkg::*;

  logic        clk, reset;
  logic        dma_trans_start, direction_bit, int_enabled, clear_int;
  logic [15:0] dma_p1_start_addr, dma_p2_start_addr, dma_transfer_len;
  logic        int_gen, dma_busy, dma_error, mst_en;
  logic [1:0]  mst_we;
  logic [15:0] mst_addr, mst_wdata, mst_rdata;
  logic        mst_ready, mst_resp;

  dma_engine #(
    .TIMEOUT_CYCLES(4),
    .ADDR_STEP     (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dma_trans_start  (dma_trans_start),
    .direction_bit    (direction_bit),
    .int_enabled      (int_enabled),
    .dma_p1_start_addr(dma_p1_start_addr),
    .dma_p2_start_addr(dma_p2_start_addr),
    .dma_transfer_len (dma_transfer_len),
    .clear_int        (clear_int),
    .int_gen          (int_gen),
    .dma_busy         (dma_busy),
    .dma_error        (dma_error),
    .mst_en           (mst_en),
    .mst_we           (mst_we),
    .mst_addr         (mst_addr),
    .mst_wdata        (mst_wdata),
    .mst_rdata        (mst_rdata),
    .mst_ready        (mst_ready),
    .mst_resp         (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  typedef struct {
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;
  txn_t sb[$];

  // Bus responder configuration.
  int unsigned rsp_wait;
  int          rsp_err_at;
  int unsigned rsp_idx;

  initial begin : responder
    int unsigned wcnt;
    logic [15:0] held_addr;
    logic [1:0]  held_we;
    txn_t        e;
    wcnt = 0;
    mst_ready = 1'b0;
    mst_resp  = 1'b0;
    mst_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mst_ready = 1'b0;
      mst_resp  = 1'b0;
      mst_rdata = 16'h0000;
      if (mst_en && !reset) begin
        if (wcnt > 0) begin
          check("req_addr_stable", mst_addr, held_addr);
          check("req_we_stable", 16'(mst_we), 16'(held_we));
        end
        held_addr = mst_addr;
        held_we   = mst_we;
        if (wcnt >= rsp_wait) begin
          wcnt      = 0;
          mst_ready = 1'b1;
          mst_resp  = (rsp_err_at == int'(rsp_idx));
          if (mst_we == MST_WE_READ) mst_rdata = mem_word(mst_addr);
          rsp_idx++;
          if (sb.size() == 0) begin
            check("unexpected_bus_txn", mst_addr, 16'hFFFF);
          end else begin
            e = sb.pop_front();
            check("bus_we", 16'(mst_we), 16'(e.we));
            check("bus_addr", mst_addr, e.addr);
            if (e.we == MST_WE_WORD) check("bus_wdata", mst_wdata, e.data);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  typedef struct {
    logic        dir;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] len;
    logic        int_en;
    int unsigned wt;
    int          err_at;
    logic        tmo;
    logic        restart;
    logic        exp_int;
    logic        exp_err;
    int unsigned exp_cyc;
  } vec_t;

  task automatic push_exp(input vec_t v);
    logic [15:0] s, d;
    int n;
    s = (v.dir ? v.p2 : v.p1) & 16'hFFFE;
    d = (v.dir ? v.p1 : v.p2) & 16'hFFFE;
    n = v.tmo ? 0 : ((v.err_at >= 0) ? v.err_at + 1 : 2 * int'(v.len));
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) begin
        sb.push_back('{MST_WE_READ, s, 16'h0000});
      end else begin
        sb.push_back('{MST_WE_WORD, d, mem_word(s)});
        s = s + 16'd2;
        d = d + 16'd2;
      end
    end
  endtask

  task automatic start_xfer(input vec_t v);
    rsp_wait   = v.wt;
    rsp_err_at = v.err_at;
    rsp_idx    = 0;
    push_exp(v);
    @(negedge clk);
    direction_bit     = v.dir;
    dma_p1_start_addr = v.p1;
    dma_p2_start_addr = v.p2;
    dma_transfer_len  = v.len;
    int_enabled       = v.int_en;
    dma_trans_start   = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int  cyc;
    logic done;
    string tag;
    tag = $sformatf("row%0d", idx);
    start_xfer(v);
    cyc  = 0;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      dma_trans_start = 1'b0;
      if (!dma_busy) begin
        done = 1'b1;
        break;
      end
      cyc++;
      if (cyc == 1) begin
        // Configuration changes after start must not affect the transfer.
        direction_bit     = ~v.dir;
        dma_p1_start_addr = 16'h0EEE;
        dma_p2_start_addr = 16'h0DDC;
        dma_transfer_len  = 16'd7;
        int_enabled       = ~v.int_en;
      end
      if (v.restart && cyc == 2) begin
        dma_trans_start   = 1'b1;
        dma_p1_start_addr = 16'h0800;
        dma_transfer_len  = 16'd5;
      end
    end
    check({tag, "_busy_timeout"}, 16'(done), 16'd1);
    check({tag, "_busy_cycles"}, 16'(cyc), 16'(v.exp_cyc));
    check({tag, "_int_gen"}, 16'(int_gen), 16'(v.exp_int));
    check({tag, "_dma_error"}, 16'(dma_error), 16'(v.exp_err));
    check({tag, "_sb_drained"}, 16'(sb.size()), 16'd0);
    repeat (3) @(negedge clk);
    check({tag, "_int_held"}, 16'(int_gen), 16'(v.exp_int));
    check({tag, "_idle_after"}, 16'(dma_busy), 16'd0);
    clear_int = 1'b1;
    @(negedge clk);
    clear_int = 1'b0;
    check({tag, "_int_cleared"}, 16'(int_gen), 16'd0);
    check({tag, "_err_cleared"}, 16'(dma_error), 16'd0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mst_en"}, 16'(mst_en), 16'd0);
    check({tag, "_mst_we"}, 16'(mst_we), 16'd0);
    check({tag, "_mst_addr"}, mst_addr, 16'h0000);
    check({tag, "_mst_wdata"}, mst_wdata, 16'h0000);
    check({tag, "_busy"}, 16'(dma_busy), 16'd0);
    check({tag, "_int_gen"}, 16'(int_gen), 16'd0);
    check({tag, "_error"}, 16'(dma_error), 16'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[8];

  initial begin : main
    logic hit;
    vec_t v;
    // dir, p1, p2, len, int_en, wait, err_at, tmo, restart, exp_int, exp_err, exp_cyc
    vecs[0] = '{1'b0, 16'h0200, 16'h0300, 16'd3, 1'b1, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 7};
    vecs[1] = '{1'b1, 16'h0500, 16'h0400, 16'd2, 1'b1, 3, -1, 1'b0, 1'b0, 1'b1, 1'b0, 17};
    vecs[2] = '{1'b0, 16'h0200, 16'h0300, 16'd0, 1'b1, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 16'h0220, 16'h0330, 16'd2, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    vecs[4] = '{1'b0, 16'h0240, 16'h0340, 16'd3, 1'b1, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1, 5};
    vecs[5] = '{1'b0, 16'h0A00, 16'h0B00, 16'd2, 1'b1, 1000, -1, 1'b1, 1'b0, 1'b1, 1'b1, 5};
    vecs[6] = '{1'b0, 16'hFFFE, 16'h1000, 16'd2, 1'b1, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 5};
    vecs[7] = '{1'b1, 16'h0601, 16'h0203, 16'd1, 1'b1, 1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 5};

    reset = 1'b1;
    dma_trans_start = 1'b0;
    direction_bit = 1'b0;
    int_enabled = 1'b0;
    clear_int = 1'b0;
    dma_p1_start_addr = 16'h0000;
    dma_p2_start_addr = 16'h0000;
    dma_transfer_len = 16'h0000;
    rsp_wait = 0;
    rsp_err_at = -1;
    rsp_idx = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_row(vecs[i], i);

    // Clear requested in the DONE cycle: the completion set must win.
    v = '{1'b0, 16'h0100, 16'h0180, 16'd1, 1'b1, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    start_xfer(v);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      dma_trans_start = 1'b0;
      if (dma_busy && !mst_en) begin
        hit = 1'b1;
        break;
      end
    end
    check("done_seen", 16'(hit), 16'd1);
    clear_int = 1'b1;
    @(negedge clk);
    clear_int = 1'b0;
    check("clear_vs_set_int", 16'(int_gen), 16'd1);
    check("clear_vs_set_busy", 16'(dma_busy), 16'd0);
    clear_int = 1'b1;
    @(negedge clk);
    clear_int = 1'b0;
    check("clear_after_done", 16'(int_gen), 16'd0);
    sb.delete();

    // Reset asserted while a write is waiting for ready.
    v = '{1'b0, 16'h0600, 16'h0700, 16'd2, 1'b1, 2, -1, 1'b0, 1'b0, 1'b1, 1'b0, 13};
    start_xfer(v);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      dma_trans_start = 1'b0;
      if (mst_en && mst_we == MST_WE_WORD) begin
        hit = 1'b1;
        break;
      end
    end
    check("write_seen", 16'(hit), 16'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
    run_row(vecs[0], 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
- Transfer sequencer for the openMSP430 DMA peripheral.
- Consumes the configuration and start pulse produced by the DMA register block: direction, port1/port2 start addresses, transfer length and interrupt enable.
- Moves 16-bit words one at a time over a single-master memory bus (read from source, then write to destination).
- Returns busy, interrupt and error status to the register block.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles a bus request may wait for mst_ready before the transfer is aborted (1..255).
- ADDR_STEP, 2, byte increment applied to source and destination addresses after each word.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- dma_trans_start  input  1  one-cycle start pulse
- direction_bit  input  1  0: port1 -> port2; 1: port2 -> port1
- int_enabled  input  1  enables setting int_gen on completion
- dma_p1_start_addr  input  16  port1 start byte address
- dma_p2_start_addr  input  16  port2 start byte address
- dma_transfer_len  input  16  number of words to move
- clear_int  input  1  pulse; clears int_gen and dma_error
- int_gen  output  1  sticky completion interrupt
- dma_busy  output  1  high while a transfer is in progress
- dma_error  output  1  sticky bus-error / timeout flag
- mst_en  output  1  bus request
- mst_we  output  2  00 = read, 11 = word write
- mst_addr  output  16  bus byte address; bit 0 always 0
- mst_wdata  output  16  write data
- mst_rdata  input  16  read data, valid in the cycle mst_ready = 1
- mst_ready  input  1  request accepted / completed this cycle
- mst_resp  input  1  error response, qualified by mst_ready

Behaviour:
- Reset: state IDLE; all outputs 0; internal src/dst/count/data/timer registers 0. Reset mid-transfer abandons it with no completion interrupt.
- States: IDLE, READ, WRITE, DONE, ABORT.
- IDLE:
  - dma_trans_start = 1 and dma_transfer_len != 0: latch src/dst (bit 0 forced 0) and count = len; go to READ.
  - Source/destination: direction_bit 0 → src = p1, dst = p2; direction_bit 1 → src = p2, dst = p1.
  - dma_transfer_len = 0: go directly to DONE; no bus activity.
  - Configuration inputs are sampled only at start; later changes do not affect the running transfer.
- READ:
  - Drives mst_en = 1, mst_we = 00, mst_addr = src; request held stable until mst_ready.
  - mst_ready & !mst_resp: capture mst_rdata; src += ADDR_STEP; go to WRITE.
- WRITE:
  - Drives mst_en = 1, mst_we = 11, mst_addr = dst, mst_wdata = captured word.
  - mst_ready & !mst_resp: dst += ADDR_STEP; count -= 1. Go to DONE if count was 1, else READ.
  - No idle cycle between WRITE and the next READ.
- Address arithmetic is 16-bit modulo: 0xFFFE + 2 = 0x0000, with no error.
- Timeout timer:
  - Cleared on every entry to READ/WRITE; increments each cycle mst_en = 1 and mst_ready = 0.
  - Reaching TIMEOUT_CYCLES → ABORT.
- mst_ready & mst_resp in READ or WRITE → ABORT; no address or count update.
- DONE (1 cycle): set int_gen if int_enabled (latched at start); go to IDLE.
- ABORT (1 cycle): set dma_error; set int_gen if int_enabled; go to IDLE.
- mst_en is 0 in IDLE/DONE/ABORT. When mst_en = 0, mst_we, mst_addr and mst_wdata are 0.
- dma_busy = 1 in READ, WRITE, DONE and ABORT; it is registered, so it rises the cycle after start.
- dma_trans_start while busy is ignored.
- clear_int in the same cycle as a set of int_gen or dma_error: set wins.
- Latency: start at cycle N → first mst_en at N+1. With zero-wait bus, one word takes 2 cycles; len = L completes with int_gen high at N+2L+2.

Decomposition:
- Package dma_pkg: state encoding constants, MST_WE_READ = 2'b00, MST_WE_WORD = 2'b11, timer width (8).
- One sub-module dma_timeout_cnt: clear, enable and hit inputs; saturating 8-bit counter compared against TIMEOUT_CYCLES.

Test Plan:
1. Basic transfer, zero-wait bus. p1 = 0x0200, p2 = 0x0300, len = 3, dir = 0, int_en = 1. → Reads at 0x0200/0x0202/0x0204, each followed by a write of that data to 0x0300/0x0302/0x0304. dma_busy high 7 cycles; int_gen set at N+8 and held until clear_int.
2. Reverse direction with wait states. dir = 1, p2 = 0x0400, p1 = 0x0500, len = 2, mst_ready delayed 3 cycles per request. → Request signals stable while waiting; reads from 0x0400, writes to 0x0500; no timeout.
3. Zero length and interrupt disabled. len = 0, int_en = 1 → no mst_en, int_gen set at N+2. len = 2, int_en = 0 → transfer completes, int_gen stays 0.
4. Bus error on the second write. mst_resp = 1 with ready → ABORT; dma_error = 1; dma_busy drops. clear_int then clears both flags. A second start pulse during the transfer is ignored.
5. Timeout and address wrap.
   - TIMEOUT_CYCLES = 4, mst_ready tied 0 → ABORT after 4 waiting cycles.
   - Separately, p1 = 0xFFFE, len = 2 → second read at 0x0000.
6. Reset mid-WRITE, plus simultaneous clear and set.
   - Reset mid-WRITE → all outputs 0 immediately; next start behaves normally.
   - clear_int in the DONE cycle → int_gen remains 1.
